// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, reused LSB-first over WIDTH cycles.
// A start pulse launches the addition; a done pulse follows, and at that point the sum and carry-out have just been updated.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one operand bit pair consumed per clock, busy=1
//   DONE   | one-cycle done pulse; a start here is accepted as in IDLE
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_bit;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             w_last;
   logic             w_accept;

   assign w_bit       = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
   assign w_carry_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
   // Shifting the concatenation keeps this valid at WIDTH=1, where acc is just the new bit.
   assign w_acc_nxt   = WIDTH'({w_bit, r_acc} >> 1);
   assign w_last      = (r_cnt == CW'(WIDTH - 1));
   assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a_sh  <= a_in;
         r_b_sh  <= b_in;
         r_carry <= cin;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else if (r_state == S_RUN) begin
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_carry <= w_carry_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= r_cnt + 1'b1;
         // Results are published only on the last bit, so sum never shows a partial value.
         if (w_last) begin
            r_sum  <= w_acc_nxt;
            r_cout <= w_carry_nxt;
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a vector table at WIDTH=8, back-to-back, ignored-start,
// mid-RUN reset and random sequences, plus a WIDTH=1 instance walked through the full-adder truth table.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   logic         start1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         cin1;
   logic         busy1;
   logic         done1;
   logic [0:0]   sum1;
   logic         cout1;

   int           n_vec;
   int           n_err;
   logic [W-1:0] prev_sum;
   logic         prev_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts an addition now and returns in the cycle after edge W, which must be the done cycle.
   // ign_at > 0 pulses a start carrying junk operands before that RUN edge.
   task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input int ign_at);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      cin   = c;
      tick();
      start = 1'b0;
      a_in  = $urandom_range(255, 0);
      b_in  = $urandom_range(255, 0);
      cin   = 1'($urandom_range(1, 0));
      chk("busy_run", 32'(busy), 32'd1);
      chk("sum_hold", 32'({cout, sum}), 32'({prev_cout, prev_sum}));
      for (int k = 1; k < W; k++) begin
         if (k == ign_at) begin
            start = 1'b1;
            a_in  = 8'hFF;
            b_in  = 8'hFF;
            cin   = 1'b1;
         end
         tick();
         start = 1'b0;
         chk("busy_run", 32'(busy), 32'd1);
         chk("done_run", 32'(done), 32'd0);
         chk("sum_hold", 32'({cout, sum}), 32'({prev_cout, prev_sum}));
      end
      tick();
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("sum", 32'(sum), 32'(es));
      chk("cout", 32'(cout), 32'(ec));
      prev_sum  = es;
      prev_cout = ec;
   endtask

   initial begin : main
      logic [1:0]   fa_exp [8];
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   rs;

      n_vec     = 0;
      n_err     = 0;
      prev_sum  = '0;
      prev_cout = 1'b0;

      vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      fa_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      rst_n  = 1'b0;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      cin    = 1'b0;
      start1 = 1'b0;
      a1     = '0;
      b1     = '0;
      cin1   = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_add(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].es, vecs[i].ec, -1);
         tick();
         chk("done_single", 32'(done), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Start presented in the DONE cycle is taken immediately.
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
      run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
      tick();
      chk("b2b_done_end", 32'(done), 32'd0);

      // Start during RUN cycle 3 must be ignored.
      run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
      for (int k = 0; k < W + 2; k++) begin
         tick();
         chk("ign_no_run", 32'({busy, done}), 32'd0);
      end

      // Reset at RUN cycle 4 discards the in-flight add.
      start = 1'b1;
      a_in  = 8'h80;
      b_in  = 8'h80;
      cin   = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < W + 4; k++) begin
         tick();
         chk("post_rst_quiet", 32'({busy, done}), 32'd0);
      end
      prev_sum  = '0;
      prev_cout = 1'b0;

      // WIDTH=1 truth table.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         idx    = 3'(i);
         start1 = 1'b1;
         a1     = idx[2];
         b1     = idx[1];
         cin1   = idx[0];
         tick();
         start1 = 1'b0;
         chk("w1_busy", 32'({busy1, done1}), 32'b10);
         tick();
         chk("w1_done", 32'({busy1, done1}), 32'b01);
         chk("w1_fa", 32'({cout1, sum1}), 32'(fa_exp[i]));
         tick();
         chk("w1_idle", 32'(done1), 32'd0);
      end

      // Random back-to-back stream; fixed done timing inside run_add enforces W+1 spacing.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(255, 0));
         rb = 8'($urandom_range(255, 0));
         rc = 1'($urandom_range(1, 0));
         rs = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         run_add(ra, rb, rc, rs[W-1:0], rs[W], -1);
      end
      tick();
      chk("rand_end_done", 32'(done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
